// File: rtl/pokey_clock_scheduler_pkg.sv
// Shared POKEY timing constants: AUDCTL bit positions, default divider ratios
// and the scheduler state encoding.
package pokey_clock_scheduler_pkg;

   localparam int AUDCTL_15K     = 0;
   localparam int AUDCTL_CH3_179 = 5;
   localparam int AUDCTL_CH1_179 = 6;

   localparam int DIV64_DEF = 28;
   localparam int DIV15_DEF = 114;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/pokey_clock_scheduler_tick_divider.sv
// Divides the 1.79 MHz enable by DIV. The wrap tick sets a flag, and the owner
// qualifies that flag with the next enable tick to form the output pulse.
module pokey_tick_divider #(
   parameter int DIV  = 28,
   parameter int LOAD = 0
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_en,
   input  logic i_hold,
   output logic o_flag
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   localparam logic [W-1:0] LVAL = W'(LOAD);

   logic [W-1:0] r_cnt;
   logic         r_flag;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt  <= '0;
         r_flag <= 1'b0;
      end else if (i_hold) begin
         r_cnt  <= LVAL;
         r_flag <= 1'b0;
      end else if (i_en) begin
         if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_flag <= 1'b1;
         end else begin
            r_cnt  <= r_cnt + W'(1);
            r_flag <= 1'b0;
         end
      end
   end

   assign o_flag = r_flag;

endmodule

// File: rtl/pokey_clock_scheduler.sv
// POKEY base timing: 64/15 kHz enables, per-channel clock select from AUDCTL,
// SKCTL init-mode sequencing and STIMER reload requests.
module pokey_clock_scheduler
   import pokey_clock_scheduler_pkg::*;
#(
   parameter int DIV64   = DIV64_DEF,
   parameter int DIV15   = DIV15_DEF,
   parameter int RESET64 = 0,
   parameter int RESET15 = 0
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_enable_179,
   input  logic       i_init_mode,
   input  logic [7:0] i_audctl,
   input  logic       i_stimer_strobe,
   output logic       o_enable_64,
   output logic       o_enable_15,
   output logic [3:0] o_chan_en,
   output logic [3:0] o_reload,
   output logic       o_running
);

   state_e     r_state;
   state_e     w_next;
   logic [3:0] r_reload;
   logic       w_running;
   logic       w_hold;
   logic       w_flag64;
   logic       w_flag15;
   logic       w_en64;
   logic       w_en15;
   logic       w_base;
   logic       w_fast;
   logic       w_unused_audctl;

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_INIT: if (!i_init_mode) w_next = ST_ARM;
         ST_ARM:  w_next = i_init_mode ? ST_INIT : ST_RUN;
         ST_RUN:  if (i_init_mode) w_next = ST_INIT;
         default: w_next = ST_INIT;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state  <= ST_INIT;
         r_reload <= 4'h0;
      end else begin
         r_state  <= w_next;
         // A strobe in the same cycle init_mode rises is still taken from RUN.
         r_reload <= (i_stimer_strobe && (r_state != ST_INIT)) ? 4'hF : 4'h0;
      end
   end

   assign w_running = (r_state == ST_RUN);
   // Dividers only count in RUN; entering INIT forces them on the same edge.
   assign w_hold    = !w_running || i_init_mode;

   pokey_tick_divider #(.DIV(DIV64), .LOAD(RESET64)) u_div64 (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_en      (i_enable_179),
      .i_hold    (w_hold),
      .o_flag    (w_flag64)
   );

   pokey_tick_divider #(.DIV(DIV15), .LOAD(RESET15)) u_div15 (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_en      (i_enable_179),
      .i_hold    (w_hold),
      .o_flag    (w_flag15)
   );

   assign w_en64 = w_flag64 & i_enable_179 & w_running;
   assign w_en15 = w_flag15 & i_enable_179 & w_running;
   assign w_fast = i_enable_179 & w_running;
   assign w_base = i_audctl[AUDCTL_15K] ? w_en15 : w_en64;

   assign o_enable_64 = w_en64;
   assign o_enable_15 = w_en15;
   assign o_chan_en   = {w_base,
                         i_audctl[AUDCTL_CH3_179] ? w_fast : w_base,
                         w_base,
                         i_audctl[AUDCTL_CH1_179] ? w_fast : w_base};
   assign o_reload    = r_reload;
   assign o_running   = w_running;

   // Remaining AUDCTL bits belong to the channel timers, not to this block.
   assign w_unused_audctl = ^{i_audctl[7], i_audctl[4:1]};

endmodule
